// File: rtl/fht_pkg.sv
// Shared definitions for the FHT front end.
// Provides the frame geometry, the input-buffer state encoding and a helper that
// extracts sample k from a packed frame, where sample k lives at [k*FHT_DW +: FHT_DW].
package fht_pkg;

    localparam int unsigned FHT_N  = 16;  // samples per frame (FHT size)
    localparam int unsigned FHT_DW = 14;  // input sample width
    localparam int unsigned FHT_OW = 15;  // butterfly output width
    localparam int unsigned FHT_CW = 4;   // log2(FHT_N)

    typedef enum logic {
        StIdle = 1'b0,
        StFill = 1'b1
    } fht_state_e;

    function automatic logic [FHT_DW-1:0] fht_slice(input logic [FHT_N*FHT_DW-1:0] frame,
                                                    input int unsigned            k);
        return frame[k*FHT_DW +: FHT_DW];
    endfunction

endpackage

// File: rtl/fht_in_buffer.sv
// Serial-to-parallel input buffer in front of the 16-point FHT stage.
// Collects N consecutive DW-bit samples into a shadow bank and, on the last sample,
// copies the whole frame into the output bank and pulses FhtStar for one cycle.
// The output bank is held while the next frame fills.
//
// Ports:
//   Clk       chip clock
//   Reset     synchronous, active-high reset
//   SymStart  symbol boundary; the current (if InValid) or next sample is sample 0
//   InValid   InData is valid this cycle
//   InData    compensated chip sample
//   FhtStar   1-cycle pulse: DataOut holds a new complete frame
//   DataOut   frame; sample k at [k*DW +: DW]
//   FrameCnt  completed-frame count, wraps
//   FrameErr  1-cycle pulse: partial frame discarded by SymStart
module fht_in_buffer
    import fht_pkg::*;
#(
    parameter int unsigned DW = FHT_DW,
    parameter int unsigned N  = FHT_N,
    parameter int unsigned CW = FHT_CW,
    parameter int unsigned FW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          SymStart,
    input  logic          InValid,
    input  logic [DW-1:0] InData,
    output logic          FhtStar,
    output logic [N*DW-1:0] DataOut,
    output logic [FW-1:0] FrameCnt,
    output logic          FrameErr
);

    fht_state_e    state_q;
    logic [CW-1:0] pos_q;

    // The last sample of a frame bypasses the shadow bank straight into DataOut,
    // so only N-1 shadow slots are ever read.
    logic [DW-1:0] shadow_q [N-1];

    logic          in_fill;
    logic          last_pos;
    logic          complete;
    logic          resync;
    logic          wr_en;
    logic [CW-1:0] wr_idx;

    assign in_fill  = (state_q == StFill);
    assign last_pos = (pos_q == CW'(N-1));
    // SymStart always wins over completion of the frame.
    assign complete = in_fill & InValid & last_pos & ~SymStart;
    assign resync   = in_fill & SymStart & (pos_q != '0);
    assign wr_en    = InValid & (SymStart | in_fill);
    assign wr_idx   = SymStart ? '0 : pos_q;

    // Shadow bank
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < N - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < N - 1; k++) begin
                if (wr_idx == CW'(k)) begin
                    shadow_q[k] <= InData;
                end
            end
        end
    end

    // Output bank: only a completed frame ever updates it
    always_ff @(posedge Clk) begin
        if (Reset) begin
            DataOut <= '0;
        end else if (complete) begin
            for (int k = 0; k < N - 1; k++) begin
                DataOut[k*DW +: DW] <= shadow_q[k];
            end
            DataOut[(N-1)*DW +: DW] <= InData;
        end
    end

    // Control, position counter and registered pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            pos_q    <= '0;
            FhtStar  <= 1'b0;
            FrameErr <= 1'b0;
            FrameCnt <= '0;
        end else begin
            FhtStar  <= complete;
            FrameErr <= resync;
            if (complete) begin
                FrameCnt <= FrameCnt + 1'b1;
            end
            if (SymStart) begin
                state_q <= StFill;
                pos_q   <= InValid ? CW'(1) : '0;
            end else if (in_fill && InValid) begin
                // Wraps to 0 on completion since N == 2**CW
                pos_q <= pos_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fht_in_buffer.sv
module tb_fht_in_buffer;
    import fht_pkg::*;

    localparam int DW = FHT_DW;
    localparam int N  = FHT_N;
    localparam int FW = 8;

    typedef logic [N*DW-1:0] frame_t;
    typedef struct {
        frame_t         frame;
        logic [FW-1:0]  cnt;
        int             cyc;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          SymStart = 1'b0;
    logic          InValid = 1'b0;
    logic [DW-1:0] InData = '0;
    logic          FhtStar;
    frame_t        DataOut;
    logic [FW-1:0] FrameCnt;
    logic          FrameErr;

    fht_in_buffer dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .SymStart (SymStart),
        .InValid  (InValid),
        .InData   (InData),
        .FhtStar  (FhtStar),
        .DataOut  (DataOut),
        .FrameCnt (FrameCnt),
        .FrameErr (FrameErr)
    );

    always #5 Clk = ~Clk;

    exp_t          exp_q[$];
    int            err_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    logic [FW-1:0] exp_cnt = '0;
    frame_t        prev_out = '0;

    task automatic chk(input string name, input frame_t act, input frame_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: runs on the falling edge, away from the active edge.
    always @(negedge Clk) begin : monitor
        exp_t e;
        int   ec;
        if (FhtStar === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fhtstar", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("fhtstar_cycle", frame_t'(cyc), frame_t'(e.cyc));
                chk("frame_data", DataOut, e.frame);
                chk("frame_cnt", frame_t'(FrameCnt), frame_t'(e.cnt));
            end
        end
        if (FrameErr === 1'b1) begin
            if (err_q.size() == 0) begin
                chk("unexpected_frameerr", 1, 0);
            end else begin
                ec = err_q.pop_front();
                chk("frameerr_cycle", frame_t'(cyc), frame_t'(ec));
            end
        end
        if (Reset === 1'b0) begin
            chk("pulse_exclusive", frame_t'(FhtStar & FrameErr), 0);
            if (FhtStar !== 1'b1) chk("dataout_hold", DataOut, prev_out);
        end
        prev_out = DataOut;
        cyc++;
    end

    task automatic drive(input logic sym, input logic vld, input logic [DW-1:0] d);
        @(negedge Clk);
        #1;
        SymStart = sym;
        InValid  = vld;
        InData   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    function automatic frame_t pack(input logic [DW-1:0] s [N]);
        frame_t f;
        for (int k = 0; k < N; k++) f[k*DW +: DW] = s[k];
        return f;
    endfunction

    task automatic push_frame(input logic [DW-1:0] s [N]);
        exp_t e;
        exp_cnt++;
        e.frame = pack(s);
        e.cnt   = exp_cnt;
        e.cyc   = cyc;
        exp_q.push_back(e);
    endtask

    // Sends one frame; the expectation is queued while the last sample is on the bus.
    task automatic send_frame(input logic [DW-1:0] s [N], input logic sym_first,
                              input logic gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps && k > 0) idle((k % 5) + 1);
            drive(sym_first && (k == 0), 1'b1, s[k]);
        end
        push_frame(s);
    endtask

    logic [DW-1:0] fa [N];
    logic [DW-1:0] fb [N];

    initial begin
        // 1) reset, then ramp without SymStart: ignored
        Reset = 1'b1;
        idle(3);
        chk("reset_fhtstar", frame_t'(FhtStar), 0);
        chk("reset_frameerr", frame_t'(FrameErr), 0);
        chk("reset_dataout", DataOut, 0);
        chk("reset_framecnt", frame_t'(FrameCnt), 0);
        Reset = 1'b0;
        for (int k = 0; k < N; k++) drive(1'b0, 1'b1, DW'(k));
        idle(2);
        chk("idle_dataout", DataOut, 0);
        chk("idle_framecnt", frame_t'(FrameCnt), 0);

        // 2) basic frame 1..15, 0x3FFF
        for (int k = 0; k < N - 1; k++) fa[k] = DW'(k + 1);
        fa[N-1] = 14'h3FFF;
        send_frame(fa, 1'b1, 1'b0);
        idle(1);
        chk("t2_slot0", frame_t'(fht_slice(DataOut, 0)), frame_t'(14'h0001));
        chk("t2_slot15", frame_t'(fht_slice(DataOut, 15)), frame_t'(14'h3FFF));
        chk("t2_framecnt", frame_t'(FrameCnt), 1);

        // 3) same frame with gaps
        send_frame(fa, 1'b1, 1'b1);
        idle(1);
        chk("t3_framecnt", frame_t'(FrameCnt), 2);

        // 4) 48 continuous samples after a single SymStart
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) fb[k] = DW'(16'h0100 + f * 16 + k);
            send_frame(fb, (f == 0), 1'b0);
        end
        idle(1);
        chk("t4_framecnt", frame_t'(FrameCnt), 5);

        // 5) resync at position 9
        for (int k = 0; k < 9; k++) drive(1'b0, 1'b1, DW'(16'h0200 + k));
        drive(1'b1, 1'b1, 14'h2000);
        err_q.push_back(cyc);
        fb[0] = 14'h2000;
        for (int k = 1; k < N; k++) begin
            fb[k] = DW'(16'h2100 + k);
            drive(1'b0, 1'b1, fb[k]);
        end
        push_frame(fb);
        idle(1);
        chk("t5_slot0", frame_t'(fht_slice(DataOut, 0)), frame_t'(14'h2000));

        // SymStart together with the last sample: resync wins, sample becomes sample 0
        for (int k = 0; k < N - 1; k++) drive(1'b0, 1'b1, DW'(16'h00A0 + k));
        drive(1'b1, 1'b1, 14'h1555);
        err_q.push_back(cyc);
        fb[0] = 14'h1555;
        for (int k = 1; k < N; k++) begin
            fb[k] = DW'(16'h0C00 + k);
            drive(1'b0, 1'b1, fb[k]);
        end
        push_frame(fb);

        // SymStart without a sample mid-frame: error, next sample is sample 0
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, DW'(16'h0333));
        drive(1'b1, 1'b0, '0);
        err_q.push_back(cyc);
        for (int k = 0; k < N; k++) fb[k] = DW'(16'h3000 + 7 * k);
        send_frame(fb, 1'b0, 1'b0);
        idle(1);
        chk("t5_framecnt", frame_t'(FrameCnt), 8);

        // 6) reset at position 7, then samples ignored until SymStart
        for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, DW'(16'h0444 + k));
        @(negedge Clk);
        #1;
        Reset   = 1'b1;
        InValid = 1'b1;
        exp_cnt = '0;
        drive(1'b0, 1'b0, '0);
        Reset = 1'b0;
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, DW'(16'h0555 + k));
        idle(2);
        chk("t6_framecnt", frame_t'(FrameCnt), 0);
        chk("t6_dataout", DataOut, 0);
        send_frame(fa, 1'b1, 1'b0);
        idle(2);
        chk("t6_framecnt_after", frame_t'(FrameCnt), 1);

        idle(3);
        chk("pending_frames", frame_t'(exp_q.size()), 0);
        chk("pending_errors", frame_t'(err_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
